// File: rtl/approx_error_monitor.sv
`default_nettype none
// approx_error_monitor: compares approximate sums against exact A+B and accumulates
// error-distance statistics over a programmed sample count. Rev 1.0
module approx_error_monitor #(
  parameter int WIDTH = 40,
  parameter int CNT_W = 32,
  parameter int ACC_W = 64
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] Approx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH:0]   max_ed,
  output logic [ACC_W-1:0] sum_ed
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] accepted_q, accepted_d;
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH:0]   s1_ed_q, s1_ed_d;
  logic             s1_err_q, s1_err_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [WIDTH:0]   max_ed_q, max_ed_d;
  logic [ACC_W-1:0] sum_ed_q, sum_ed_d;

  logic [WIDTH:0]   w_exact;
  logic [WIDTH:0]   w_approx;
  logic [WIDTH:0]   w_ed;
  logic             w_accept;
  logic [ACC_W:0]   w_sum_ext;

  assign w_exact   = {1'b0, A} + {1'b0, B};
  assign w_approx  = {1'b0, Approx};
  assign w_ed      = (w_exact >= w_approx) ? (w_exact - w_approx) : (w_approx - w_exact);
  assign in_ready  = (state_q == S_RUN) && (accepted_q < target_q);
  assign w_accept  = in_valid && in_ready;
  // Extra carry bit detects accumulator overflow for saturation.
  assign w_sum_ext = {1'b0, sum_ed_q} + (ACC_W + 1)'(s1_ed_q);

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    accepted_d   = accepted_q;
    s1_valid_d   = w_accept;
    s1_ed_d      = s1_ed_q;
    s1_err_d     = s1_err_q;
    sample_cnt_d = sample_cnt_q;
    err_cnt_d    = err_cnt_q;
    max_ed_d     = max_ed_q;
    sum_ed_d     = sum_ed_q;

    if (w_accept) begin
      s1_ed_d  = w_ed;
      s1_err_d = |w_ed;
    end

    if (s1_valid_q) begin
      if (sample_cnt_q != '1) sample_cnt_d = sample_cnt_q + CNT_W'(1);
      if (s1_err_q && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
      if (s1_ed_q > max_ed_q) max_ed_d = s1_ed_q;
      sum_ed_d = w_sum_ext[ACC_W] ? '1 : w_sum_ext[ACC_W-1:0];
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          target_d     = num_samples;
          accepted_d   = '0;
          sample_cnt_d = '0;
          err_cnt_d    = '0;
          max_ed_d     = '0;
          sum_ed_d     = '0;
          state_d      = (num_samples == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_accept) begin
          accepted_d = accepted_q + CNT_W'(1);
          if ((accepted_q + CNT_W'(1)) == target_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!s1_valid_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_L) begin
      state_q      <= S_IDLE;
      target_q     <= '0;
      accepted_q   <= '0;
      s1_valid_q   <= 1'b0;
      s1_ed_q      <= '0;
      s1_err_q     <= 1'b0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      max_ed_q     <= '0;
      sum_ed_q     <= '0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      accepted_q   <= accepted_d;
      s1_valid_q   <= s1_valid_d;
      s1_ed_q      <= s1_ed_d;
      s1_err_q     <= s1_err_d;
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      max_ed_q     <= max_ed_d;
      sum_ed_q     <= sum_ed_d;
    end
  end

  assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign sample_cnt = sample_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign max_ed     = max_ed_q;
  assign sum_ed     = sum_ed_q;

endmodule
`default_nettype wire

// File: tb/tb_approx_error_monitor.sv
`default_nettype none
// tb_approx_error_monitor: directed runs with a per-sample error-distance scoreboard.
module tb_approx_error_monitor;
  localparam int W  = 40;
  localparam int CW = 32;
  localparam int AW = 64;

  logic          clock = 1'b0;
  logic          reset_L = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_samples = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  A = '0, B = '0, Approx = '0;
  logic          busy, done;
  logic [CW-1:0] sample_cnt, err_cnt;
  logic [W:0]    max_ed;
  logic [AW-1:0] sum_ed;

  int n_cmp = 0;
  int n_err = 0;
  logic [W:0] sb_q[$];
  logic [63:0] last_c, last_e, last_m, last_s;

  approx_error_monitor #(.WIDTH(W), .CNT_W(CW), .ACC_W(AW)) dut (
    .clock(clock), .reset_L(reset_L), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B), .Approx(Approx),
    .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .max_ed(max_ed), .sum_ed(sum_ed)
  );

  always #5 clock = ~clock;

  function automatic logic [W:0] model_ed(logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] ap);
    logic [W:0] ex, apx;
    ex  = (W + 1)'(a) + (W + 1)'(b);
    apx = (W + 1)'(ap);
    return (ex >= apx) ? (ex - apx) : (apx - ex);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic v, input logic st, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] ap);
    @(negedge clock);
    in_valid = v; start = st; A = a; B = b; Approx = ap;
    if (v && in_ready) sb_q.push_back(model_ed(a, b, ap));
  endtask

  task automatic start_run(input logic [CW-1:0] n);
    @(negedge clock);
    in_valid = 1'b0; start = 1'b1; num_samples = n;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    @(negedge clock);
    in_valid = 1'b0; start = 1'b0;
    while (!done && k < 50) begin
      @(negedge clock);
      k++;
    end
    chk({tag, ".done"}, 64'(done), 64'd1);
  endtask

  task automatic sb_check(input string tag);
    logic [63:0] c, e, m, s;
    logic [W:0]  d;
    c = 0; e = 0; m = 0; s = 0;
    while (sb_q.size() > 0) begin
      d = sb_q.pop_front();
      c = c + 1;
      if (d != 0) e = e + 1;
      if (64'(d) > m) m = 64'(d);
      s = s + 64'(d);
    end
    last_c = c; last_e = e; last_m = m; last_s = s;
    chk({tag, ".sample_cnt"}, 64'(sample_cnt), c);
    chk({tag, ".err_cnt"},    64'(err_cnt),    e);
    chk({tag, ".max_ed"},     64'(max_ed),     m);
    chk({tag, ".sum_ed"},     sum_ed,          s);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    chk("rst.in_ready", 64'(in_ready), 0);
    chk("rst.busy", 64'(busy), 0);
    chk("rst.done", 64'(done), 0);
    chk("rst.sample_cnt", 64'(sample_cnt), 0);
    chk("rst.sum_ed", sum_ed, 0);
    reset_L = 1'b1;

    // Single exact sample
    start_run(1);
    chk("r1.busy", 64'(busy), 1);
    beat(1, 0, 40'd3, 40'd5, 40'd8);
    wait_done("r1");
    sb_check("r1");
    chk("r1.ready_in_done", 64'(in_ready), 0);

    // Three samples with mixed error
    start_run(3);
    beat(1, 0, 40'd1, 40'd1, 40'd0);
    beat(1, 0, 40'd4, 40'd4, 40'd9);
    beat(1, 0, 40'd0, 40'd0, 40'd0);
    wait_done("r3");
    sb_check("r3");
    chk("r3.sum_const", sum_ed, 64'd3);
    repeat (5) @(negedge clock);
    chk("r3.hold_cnt", 64'(sample_cnt), last_c);
    chk("r3.hold_sum", sum_ed, last_s);
    chk("r3.hold_done", 64'(done), 1);

    // Carry-out of the exact sum
    start_run(1);
    beat(1, 0, {W{1'b1}}, 40'd1, 40'd0);
    wait_done("carry");
    sb_check("carry");
    chk("carry.max_const", 64'(max_ed), 64'h100_0000_0000);

    // Valid gaps, extra beat, start ignored in RUN
    start_run(4);
    beat(1, 0, 40'd10, 40'd20, 40'd31);
    beat(0, 0, 40'd99, 40'd99, 40'd0);
    beat(1, 1, 40'd7, 40'd7, 40'd14);
    beat(0, 0, 40'd5, 40'd5, 40'd5);
    beat(0, 0, 40'd5, 40'd5, 40'd5);
    chk("gap.busy_after_start", 64'(busy), 1);
    beat(1, 0, 40'd100, 40'd0, 40'd64);
    beat(1, 0, 40'd2, 40'd2, 40'd6);
    beat(1, 0, 40'd1000, 40'd1000, 40'd0);
    chk("gap.ready_after4", 64'(in_ready), 0);
    wait_done("gap");
    sb_check("gap");
    chk("gap.cnt_const", 64'(sample_cnt), 64'd4);

    // Zero-length run, then restart
    start_run(0);
    chk("zero.done", 64'(done), 1);
    chk("zero.cnt", 64'(sample_cnt), 0);
    chk("zero.max", 64'(max_ed), 0);
    chk("zero.sum", sum_ed, 0);
    start_run(2);
    chk("re.cleared", 64'(sample_cnt), 0);
    beat(1, 0, 40'd50, 40'd50, 40'd90);
    beat(1, 0, 40'd6, 40'd1, 40'd7);
    wait_done("re");
    sb_check("re");

    // Reset mid-run after two of five samples
    start_run(5);
    beat(1, 0, 40'd3, 40'd3, 40'd1);
    beat(1, 0, 40'd8, 40'd8, 40'd16);
    @(negedge clock);
    in_valid = 1'b0; reset_L = 1'b0;
    @(negedge clock);
    reset_L = 1'b1;
    sb_q.delete();
    chk("mrst.busy", 64'(busy), 0);
    chk("mrst.done", 64'(done), 0);
    chk("mrst.in_ready", 64'(in_ready), 0);
    chk("mrst.sample_cnt", 64'(sample_cnt), 0);
    chk("mrst.err_cnt", 64'(err_cnt), 0);
    chk("mrst.max_ed", 64'(max_ed), 0);
    chk("mrst.sum_ed", sum_ed, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
